// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled animation of an N_LEDS-wide LED bank with five
// animations, pause/single-step, speed select and period-complete pulse.
module led_pattern_engine #(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        mode,
  input  logic [1:0]        speed,
  input  logic              dir,
  input  logic              pause,
  input  logic              step_req,
  output logic [N_LEDS-1:0] led,
  output logic              tick,
  output logic              wrap
);

  localparam int PW = $clog2(N_LEDS);
  localparam int LW = $clog2(N_LEDS + 1);

  localparam logic [DIV_W-1:0]  DIV_ONE  = 1;
  localparam logic [DIV_W-1:0]  DIV_ALL  = '1;
  localparam logic [N_LEDS-1:0] ONE_N    = 1;
  localparam logic [N_LEDS:0]   ONE_W    = 1;
  localparam logic [PW-1:0]     POS_ONE  = 1;
  localparam logic [PW-1:0]     POS_LAST = PW'(N_LEDS - 1);
  localparam logic [LW-1:0]     LVL_ONE  = 1;
  localparam logic [LW-1:0]     LVL_FULL = LW'(N_LEDS);

  // Shared sweep direction for ping-pong position and fill level.
  typedef enum logic {B_UP = 1'b0, B_DOWN = 1'b1} bounce_e;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [N_LEDS-1:0] cnt_q, cnt_d;
  logic [N_LEDS-1:0] rot_q, rot_d;
  logic [PW-1:0]     pos_q, pos_d;
  bounce_e           bdir_q, bdir_d;
  logic [LW-1:0]     level_q, level_d;
  logic [2:0]        mode_q;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;

  logic [DIV_W-1:0]  div_mask;
  logic [N_LEDS:0]   fill_full;
  logic              adv_pre, adv, mode_chg;

  always_comb begin
    div_mask  = DIV_ALL >> {speed, 1'b0};
    adv_pre   = !pause && ((div_cnt_q & div_mask) == div_mask);
    adv       = adv_pre || (pause && step_req);
    mode_chg  = (mode != mode_q);

    div_cnt_d = pause ? div_cnt_q : div_cnt_q + DIV_ONE;
    cnt_d     = cnt_q;
    rot_d     = rot_q;
    pos_d     = pos_q;
    bdir_d    = bdir_q;
    level_d   = level_q;
    wrap_d    = 1'b0;
    tick_d    = adv && !mode_chg;

    if (mode_chg) begin
      div_cnt_d = '0;
      cnt_d     = '0;
      rot_d     = ONE_N;
      pos_d     = '0;
      bdir_d    = B_UP;
      level_d   = '0;
    end else if (adv) begin
      case (mode)
        3'd0, 3'd1: begin
          if (dir) begin
            cnt_d  = cnt_q - ONE_N;
            wrap_d = (cnt_q == '0);
          end else begin
            cnt_d  = cnt_q + ONE_N;
            wrap_d = &cnt_q;
          end
        end
        3'd2: begin
          rot_d  = dir ? {rot_q[0], rot_q[N_LEDS-1:1]} : {rot_q[N_LEDS-2:0], rot_q[N_LEDS-1]};
          wrap_d = (rot_d == ONE_N);
        end
        3'd3: begin
          // Turning on arrival at an end keeps each end lit for one step.
          if (bdir_q == B_UP) begin
            pos_d = pos_q + POS_ONE;
            if (pos_d == POS_LAST) bdir_d = B_DOWN;
          end else begin
            pos_d = pos_q - POS_ONE;
            if (pos_d == '0) begin
              bdir_d = B_UP;
              wrap_d = 1'b1;
            end
          end
        end
        3'd4: begin
          if (bdir_q == B_UP) begin
            level_d = level_q + LVL_ONE;
            if (level_d == LVL_FULL) bdir_d = B_DOWN;
          end else begin
            level_d = level_q - LVL_ONE;
            if (level_d == '0) begin
              bdir_d = B_UP;
              wrap_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // One extra bit so level == N_LEDS yields all ones without overflow.
    fill_full = (ONE_W << level_d) - ONE_W;

    case (mode)
      3'd0:    led_d = cnt_d;
      3'd1:    led_d = cnt_d ^ (cnt_d >> 1);
      3'd2:    led_d = rot_d;
      3'd3:    led_d = ONE_N << pos_d;
      3'd4:    led_d = fill_full[N_LEDS-1:0];
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q <= '0;
      cnt_q     <= '0;
      rot_q     <= ONE_N;
      pos_q     <= '0;
      bdir_q    <= B_UP;
      level_q   <= '0;
      mode_q    <= mode;
      led_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      cnt_q     <= cnt_d;
      rot_q     <= rot_d;
      pos_q     <= pos_d;
      bdir_q    <= bdir_d;
      level_q   <= level_d;
      mode_q    <= mode;
      led_q     <= led_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with N_LEDS=8, DIV_W=8 (speed 3 ticks
// every 4 clocks). Inputs change and outputs are sampled on the falling edge.
module tb_led_pattern_engine;

  localparam int W = 9;

  logic       clock;
  logic       reset;
  logic [2:0] mode;
  logic [1:0] speed;
  logic       dir;
  logic       pause;
  logic       step_req;
  logic [7:0] led;
  logic       tick;
  logic       wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {wrap, led} per tick for the sequence runs.
  logic [W-1:0] exp_q[$];

  led_pattern_engine #(.N_LEDS(8), .DIV_W(8)) dut (
    .clock(clock), .reset(reset), .mode(mode), .speed(speed), .dir(dir),
    .pause(pause), .step_req(step_req), .led(led), .tick(tick), .wrap(wrap)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    clk_n(cycles);
    reset = 1'b0;
  endtask

  // Switch mode at a falling edge, then check the seed shown one cycle later.
  task automatic set_mode(input logic [2:0] m, input logic [7:0] seed);
    mode = m;
    clk_n(1);
    check("seed_led", led, seed);
    check("seed_tick", tick, 0);
  endtask

  task automatic run_seq(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      clk_n(4);
      check({tag, "_led"}, led, e[7:0]);
      check({tag, "_tick"}, tick, 1);
      check({tag, "_wrap"}, wrap, e[8]);
    end
  endtask

  initial begin
    logic [7:0] pp_tab[14];
    logic [7:0] fill_tab[16];
    logic [7:0] step_tab[3];
    logic       moved;

    pp_tab   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    fill_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    step_tab = '{8'h02, 8'h04, 8'h08};

    mode = 3'd0; speed = 2'd3; dir = 1'b0; pause = 1'b0; step_req = 1'b0;
    reset = 1'b1;
    clk_n(2);
    check("rst_led", led, 0);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);
    reset = 1'b0;

    // Up counter: first tick after 4 clocks, full period 256 ticks.
    clk_n(3);
    check("cnt_early_tick", tick, 0);
    clk_n(1);
    check("cnt_first_led", led, 1);
    check("cnt_first_tick", tick, 1);
    for (int k = 2; k <= 256; k++) begin
      clk_n(4);
      check("cnt_led", led, k % 256);
      check("cnt_tick", tick, 1);
      check("cnt_wrap", wrap, (k == 256) ? 1 : 0);
    end

    // Mode 0 -> 1 at cnt = 5, on a cycle where an advance would be due.
    clk_n(20);
    check("pre_chg_led", led, 5);
    clk_n(3);
    set_mode(3'd1, 8'h00);
    clk_n(3);
    check("chg_divclr_tick", tick, 0);
    clk_n(1);
    check("gray1_led", led, 8'h01);
    check("gray1_tick", tick, 1);
    clk_n(4);
    check("gray2_led", led, 8'h03);
    clk_n(4);
    check("gray3_led", led, 8'h02);
    clk_n(4);
    check("gray4_led", led, 8'h06);

    // Ping-pong, two full periods.
    set_mode(3'd3, 8'h01);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 14; i++)
        exp_q.push_back({(pp_tab[i] == 8'h01), pp_tab[i]});
    run_seq("pp");

    // Fill and drain.
    set_mode(3'd4, 8'h00);
    for (int i = 0; i < 16; i++)
      exp_q.push_back({(i == 15), fill_tab[i]});
    run_seq("fill");

    // Rotate right from the seed, then reverse without reseeding.
    dir = 1'b1;
    set_mode(3'd2, 8'h01);
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b0, 8'h40});
    exp_q.push_back({1'b0, 8'h20});
    run_seq("rot_r");
    dir = 1'b0;
    exp_q.push_back({1'b0, 8'h40});
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, 8'h01});
    run_seq("rot_l");

    // Pause holds everything for 100 clocks.
    pause = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      clk_n(1);
      if (led !== 8'h01 || tick !== 1'b0) moved = 1'b1;
    end
    check("pause_hold", moved, 0);

    // Three single steps while paused.
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      clk_n(1);
      step_req = 1'b0;
      check("step_led", led, step_tab[i]);
      check("step_tick", tick, 1);
      clk_n(1);
      check("step_tick_off", tick, 0);
      clk_n(2);
    end

    // step_req while running is ignored; prescaler resumes from where it held.
    pause = 1'b0;
    step_req = 1'b1;
    clk_n(1);
    step_req = 1'b0;
    check("nopause_step_tick", tick, 0);
    check("nopause_step_led", led, 8'h08);
    clk_n(2);
    check("resume_tick_early", tick, 0);
    clk_n(1);
    check("resume_led", led, 8'h10);
    check("resume_tick", tick, 1);

    // Off mode: LEDs dark, tick still pulses, no wrap.
    set_mode(3'd5, 8'h00);
    clk_n(4);
    check("off_led", led, 0);
    check("off_tick", tick, 1);
    check("off_wrap", wrap, 0);

    // Reset mid-animation.
    set_mode(3'd0, 8'h00);
    clk_n(12);
    check("mid_led", led, 3);
    reset = 1'b1;
    clk_n(1);
    check("midrst_led", led, 0);
    check("midrst_tick", tick, 0);
    dir = 1'b1;
    clk_n(1);
    reset = 1'b0;

    // Down counter wraps from 0 to all ones.
    clk_n(4);
    check("down_led", led, 8'hFF);
    check("down_wrap", wrap, 1);
    check("down_tick", tick, 1);
    clk_n(4);
    check("down2_led", led, 8'hFE);
    check("down2_wrap", wrap, 0);

    // Speed 2: one tick per 16 clocks.
    dir = 1'b0;
    speed = 2'd2;
    do_reset(2);
    clk_n(15);
    check("spd2_early_led", led, 0);
    check("spd2_early_tick", tick, 0);
    clk_n(1);
    check("spd2_led", led, 1);
    check("spd2_tick", tick, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
